// File: rtl/mul4b_seq.sv
// mul4b_seq: sequential 4x4 unsigned multiplier.
// A single 4-bit multiply-add row (bloque_mul4b) is reused once per
// multiplier bit, LSB first, over four RUN cycles. The running partial sum
// sits in acc, and the finished low product bits shift into lo. The 8-bit
// product is registered on P and announced by a one-cycle done pulse.

// One multiply-add row: {co,so} = {si,sx} + (x AND y).
// The sum of a 4-bit value and a gated 4-bit value always fits in 5 bits.
module bloque_mul4b (
   input  logic [3:0] x,
   input  logic       y,
   input  logic [2:0] sx,
   input  logic       si,
   output logic [3:0] so,
   output logic       co
);

   logic [4:0] sum;

   assign sum      = {1'b0, si, sx} + {1'b0, x & {4{y}}};
   assign {co, so} = sum;

endmodule

module mul4b_seq (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [7:0] P,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     next_state;

   logic [3:0] xr;
   logic [3:0] yr;
   logic [3:0] acc;
   logic [3:0] lo;
   logic [1:0] cnt;
   logic [7:0] p_r;

   logic [3:0] row_so;
   logic       row_co;
   logic       accept;
   logic       last_iter;

   // A start is honoured only when no operation is in flight.
   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign last_iter = (state == RUN) && (cnt == 2'd3);

   bloque_mul4b u_row (
      .x  (xr),
      .y  (yr[0]),
      .sx (acc[2:0]),
      .si (acc[3]),
      .so (row_so),
      .co (row_co)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: four RUN cycles, one DONE cycle, DONE may chain into RUN.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (cnt == 2'd3) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Status flags are flopped from the next state so they come straight off registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (next_state == RUN);
         done <= (next_state == DONE);
      end
   end

   // Operand capture, shift-add iteration and product load on the final iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr  <= 4'd0;
         yr  <= 4'd0;
         acc <= 4'd0;
         lo  <= 4'd0;
         cnt <= 2'd0;
         p_r <= 8'd0;
      end else if (accept) begin
         xr  <= A;
         yr  <= B;
         acc <= 4'd0;
         lo  <= 4'd0;
         cnt <= 2'd0;
      end else if (state == RUN) begin
         acc <= {row_co, row_so[3:1]};
         lo  <= {row_so[0], lo[3:1]};
         yr  <= yr >> 1;
         cnt <= cnt + 2'd1;
         if (last_iter) begin
            p_r <= {row_co, row_so[3:1], row_so[0], lo[3:1]};
         end
      end
   end

   assign P = p_r;

endmodule

// File: tb/tb_mul4b_seq.sv
// Self-checking bench for mul4b_seq. The reference model is plain
// arithmetic: a product is A*B, P keeps the last completed product, busy
// lasts four cycles after an accepted start, and done follows for one cycle.

module tb_mul4b_seq;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic [7:0] P;
   logic       busy;
   logic       done;

   int         checks;
   int         failures;
   logic [7:0] model_p;

   mul4b_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .P     (P),
      .busy  (busy),
      .done  (done)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one multiply and follow it through RUN into its DONE cycle.
   // With scramble set, A/B/start are randomised during RUN; none of it may matter.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                         input bit scramble, input string name);
      logic [7:0] exp_p;
      exp_p = {4'd0, a} * {4'd0, b};
      start = 1'b1;
      A     = a;
      B     = b;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s run_flags cycle %0d: busy=%b done=%b, required busy=1 done=0",
                     name, k, busy, done);
         end
         checks++;
         if (P !== model_p) begin
            failures++;
            $display("[TB] FAIL %s p_stable cycle %0d: P=%02h, required %02h", name, k, P, model_p);
         end
         if (scramble) begin
            A     = 4'($urandom);
            B     = 4'($urandom);
            start = 1'($urandom_range(0, 1));
         end
         step();
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s done_flags: busy=%b done=%b, required busy=0 done=1", name, busy, done);
      end
      checks++;
      if (P !== exp_p) begin
         failures++;
         $display("[TB] FAIL %s product %0d*%0d: P=%02h, required %02h", name, a, b, P, exp_p);
      end
      model_p = exp_p;
   endtask

   // Reset and confirm every output clears.
   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      A     = 4'd0;
      B     = 4'd0;
      #23;
      checks++;
      if (P !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: P=%02h busy=%b done=%b, required P=00 busy=0 done=0",
                  P, busy, done);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      model_p = 8'd0;
   endtask

   // With start low, toggling operands must not wake the block.
   task automatic test_idle_inputs();
      for (int k = 0; k < 20; k++) begin
         A = 4'($urandom);
         B = 4'($urandom);
         step();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || P !== model_p) begin
            failures++;
            $display("[TB] FAIL idle cycle %0d: P=%02h busy=%b done=%b, required P=%02h busy=0 done=0",
                     k, P, busy, done, model_p);
         end
      end
   endtask

   // Largest operands, then P must hold through ten idle cycles.
   task automatic test_max_and_hold();
      run_op(4'd15, 4'd15, 1'b0, "max");
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
         if (P !== 8'hE1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold cycle %0d: P=%02h busy=%b done=%b, required P=e1 busy=0 done=0",
                     k, P, busy, done);
         end
      end
   endtask

   // Directed corner products.
   task automatic test_corners();
      run_op(4'd9, 4'd6, 1'b0, "9x6");
      step();
      run_op(4'd0, 4'd13, 1'b0, "0x13");
      step();
      run_op(4'd7, 4'd0, 1'b0, "7x0");
      step();
      run_op(4'd1, 4'd1, 1'b0, "1x1");
      step();
   endtask

   // All 256 operand pairs, chained back-to-back through the DONE state.
   task automatic test_sweep();
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(4'(a), 4'(b), 1'b0, "sweep");
         end
      end
      step();
   endtask

   // Start and operand changes during RUN are ignored: one result, no restart.
   task automatic test_ignore_in_run();
      run_op(4'd5, 4'd3, 1'b1, "ignore_run");
      for (int k = 0; k < 6; k++) begin
         A = 4'($urandom);
         B = 4'($urandom);
         step();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || P !== 8'h0F) begin
            failures++;
            $display("[TB] FAIL no_restart cycle %0d: P=%02h busy=%b done=%b, required P=0f busy=0 done=0",
                     k, P, busy, done);
         end
      end
   endtask

   // Start held high: the second operation is accepted in the DONE cycle, done pulses 5 apart.
   task automatic test_back_to_back();
      int done_gap;
      start = 1'b1;
      A     = 4'd3;
      B     = 4'd4;
      step();
      A = 4'd12;
      B = 4'd11;
      for (int k = 0; k < 4; k++) begin
         step();
      end
      checks++;
      if (done !== 1'b1 || P !== 8'h0C) begin
         failures++;
         $display("[TB] FAIL b2b_first: P=%02h done=%b, required P=0c done=1", P, done);
      end
      done_gap = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         done_gap++;
         if (done === 1'b1) begin
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || done_gap != 5) begin
         failures++;
         $display("[TB] FAIL b2b_gap: done=%b gap=%0d cycles, required done=1 gap=5", done, done_gap);
      end
      checks++;
      if (P !== 8'h84) begin
         failures++;
         $display("[TB] FAIL b2b_second: P=%02h, required 84", P);
      end
      model_p = 8'h84;
      step();
   endtask

   // Reset in the 2nd RUN cycle aborts without a done; the next operation works.
   task automatic test_reset_mid_run();
      start = 1'b1;
      A     = 4'd15;
      B     = 4'd15;
      step();
      start = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (P !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_outputs: P=%02h busy=%b done=%b, required P=00 busy=0 done=0",
                  P, busy, done);
      end
      model_p = 8'd0;
      for (int k = 0; k < 3; k++) begin
         step();
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || P !== 8'd0) begin
            failures++;
            $display("[TB] FAIL abort_no_done cycle %0d: P=%02h busy=%b done=%b, required P=00 busy=0 done=0",
                     k, P, busy, done);
         end
      end
      run_op(4'd2, 4'd3, 1'b0, "after_abort");
      step();
   endtask

   // Random operands with random interference during RUN, chained back-to-back.
   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         run_op(4'($urandom), 4'($urandom), 1'b1, "random");
         if ($urandom_range(0, 1) == 1) begin
            step();
         end
      end
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_p  = 8'd0;
      rst_n    = 1'b0;
      start    = 1'b0;
      A        = 4'd0;
      B        = 4'd0;
      test_reset();
      test_idle_inputs();
      test_max_and_hold();
      test_corners();
      test_sweep();
      test_ignore_in_run();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul4b_seq.md
# mul4b_seq

Sequential 4x4 unsigned multiplier built around a single instance of the 4-bit multiply-add row `bloque_mul4b`. It reuses that row once per multiplier bit instead of cascading four rows. The block registers the operands, walks the multiplier LSB-first over four cycles, and accumulates the partial sum in a shift register. It presents the 8-bit product with a one-cycle `done` pulse and sits in the datapath wherever area matters more than throughput.

## Interface
- No parameters; operand width is fixed at 4 bits and product width at 8 bits.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a multiply; sampled on the rising edge of `clk`.
- `A` input [3:0]: multiplicand, unsigned; captured on the accepted `start`.
- `B` input [3:0]: multiplier, unsigned; captured on the accepted `start`.
- `P` output [7:0]: registered product; holds its value until the next completion or reset.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse in DONE; `P` is valid from this cycle on.

## Operation
- FSM states:
  - IDLE
    - Idle state.
    - `start`=1 -> RUN.
  - RUN
    - Lasts exactly 4 cycles, with iteration counter `cnt` 0..3.
    - At the edge with `cnt`=3 -> DONE.
  - DONE
    - Lasts 1 cycle.
    - `start`=1 -> RUN (back-to-back operation).
    - Otherwise -> IDLE.
- Accepted `start`:
  - `xr`<=`A`, `yr`<=`B`, `acc`[3:0]<=0, `lo`[3:0]<=0, `cnt`<=0.
- RUN iteration `i`:
  - Row inputs: X=`xr`, Y=`yr[0]`, Sx=`acc[2:0]`, Si=`acc[3]`.
  - Row result: {Co,So} = `acc` + (`xr` AND `yr[0]`); the 5-bit result never overflows.
  - Update: `acc`<={Co,So[3:1]}, `lo`<={So[0],`lo[3:1]`}, `yr`<=`yr`>>1, `cnt`<=`cnt`+1.
- At the RUN->DONE edge, `P` is loaded with {Co,So[3:1],So[0],`lo[3:1]`}. This is the final `acc`:`lo` including the 4th iteration.
- `start` while in RUN is ignored: no reload and no queuing.
- `A` and `B` may change freely after the accepting edge without affecting the result.
- Reset, asynchronous and at any time including mid-RUN:
  - State -> IDLE.
  - `P`=0, `busy`=0, `done`=0, all internal registers 0.
  - An aborted operation produces no `done`.
  - After `rst_n` deasserts, the first accepted `start` proceeds normally.

## Timing
- Edge E0: `start`=1 sampled in IDLE or DONE.
- `busy`=1 during the cycles following E0, E1, E2 and E3 (4 cycles).
- Edge E4 performs the 4th iteration and loads `P`.
- `done`=1 for the single cycle following E4; `busy`=0 in that cycle.
- Latency from the accepting edge to `done` is 4 cycles.
- With `start` held high continuously, throughput is one product per 5 cycles.
- `P` updates only at the RUN->DONE edge; it is stable in all other cycles.
- `done` and `busy` are never high in the same cycle.
- Both `done` and `busy` are registered, with no combinational path from inputs.

## Test plan
- Reset, then `A`=15, `B`=15, `start` for 1 cycle -> `busy` high for 4 cycles, `done` 1 cycle, `P`=0xE1 (225), `P` held through 10 idle cycles.
- `A`=9, `B`=6 -> `P`=0x36; `A`=0, `B`=13 -> `P`=0x00; `A`=7, `B`=0 -> `P`=0x00; `A`=1, `B`=1 -> `P`=0x01; exhaustive 256-pair sweep matches A*B.
- `A`=5, `B`=3 start; `A`/`B` changed and `start` pulsed during RUN -> result `P`=0x0F with exactly one `done`, no restart.
- `start` held high with `A`=3, `B`=4 then `A`=12, `B`=11 accepted in the DONE cycle -> `done` pulses 5 cycles apart, `P`=0x0C then 0x84.
- `rst_n` asserted in the 2nd RUN cycle of 15*15 -> `P`=0, `busy`=0, `done` never pulses. After release, 2*3 -> `P`=0x06.
- `start` low with `A`/`B` toggling for 20 cycles after reset -> `busy`=0, `done`=0, `P`=0 throughout.
